// File: rtl/spart_pkg.sv
// Shared types and default sizes for the SPART receive path.
package spart_pkg;
  localparam int SPART_DATA_W   = 8;
  localparam int SPART_RX_DEPTH = 8;

  typedef enum logic {IDLE, ACK} rx_cap_state_t;
endpackage

// File: rtl/spart_rx_fifo_if.sv
// Receiver handshake plus processor-side read/status signals of the receive FIFO.
import spart_pkg::*;

interface spart_rx_fifo_if #(parameter int DATA_W = SPART_DATA_W);
  logic              rx_rdy;
  logic [DATA_W-1:0] rx_data;
  logic              clr_rdy;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rda;
  logic              full;
  logic              overrun;
  logic              clr_overrun;

  modport slave  (input  rx_rdy, rx_data, rd_en, clr_overrun,
                  output clr_rdy, rd_data, rda, full, overrun);
  modport master (output rx_rdy, rx_data, rd_en, clr_overrun,
                  input  clr_rdy, rd_data, rda, full, overrun);
endinterface

// File: rtl/spart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port. Not reset.
module spart_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receive FIFO: acks each receiver byte once, buffers it, flags overrun.
// Optional synchronous flush input enabled by defining SPART_RX_FIFO_FLUSH_EN.
import spart_pkg::*;

module spart_rx_fifo #(
  parameter int DEPTH  = SPART_RX_DEPTH,
  parameter int DATA_W = SPART_DATA_W
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SPART_RX_FIFO_FLUSH_EN
  input  logic flush,
`endif
  spart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rx_cap_state_t     state;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mem_rdata;
  logic              cap, rd_eff, wr_acc, drop, flush_i;

`ifdef SPART_RX_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Ack is held off during reset so a lingering rdy is only taken after release.
  assign cap     = rst_n && (state == IDLE) && bus.rx_rdy;
  assign rd_eff  = bus.rd_en && bus.rda;
  assign wr_acc  = cap && !flush_i && (!bus.full || rd_eff);
  assign drop    = cap && !flush_i && bus.full && !rd_eff;

  assign bus.clr_rdy = cap;
  assign bus.rda     = (count != '0);
  assign bus.full    = (count == CW'(DEPTH));
  assign bus.rd_data = bus.rda ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else
      case (state)
        IDLE:    if (bus.rx_rdy)  state <= ACK;
        ACK:     if (!bus.rx_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_eff) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_acc) - CW'(rd_eff);
    end

  // A drop in the same cycle as clr_overrun wins.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)               bus.overrun <= 1'b0;
    else if (drop)            bus.overrun <= 1'b1;
    else if (bus.clr_overrun) bus.overrun <= 1'b0;

  spart_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.rx_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );
endmodule
